// File: rtl/vga_timing_controller.sv
// vga_timing_controller: 640x480@60 Hz raster timing generator on the pixel clock.
// Produces pixel/line counters, active-low hsync/vsync, display enable (blank,
// high = visible), frame/vblank strobes and a completed-frame counter.
// Every output is registered and decoded from the next-state counter values,
// so all of them describe the same (DrawX, DrawY) in the same cycle.
// Optional feature: define VGA_SYNC_DELAY_EN to delay hs/vs by PIPE_DELAY clocks
// so they line up with the downstream mappers' RGB latency.
module vga_timing_controller #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so totals beyond 1024 cannot be represented.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_controller: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_controller: PIPE_DELAY must be in 1..4");
    end
  endgenerate

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_start_q, vblank_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Next raster position and the decode of that position, so registered outputs stay coherent.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = 10'd0;
      if (y_q == V_LAST) begin
        y_d = 10'd0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end

    blank_d        = (x_d < H_VIS) && (y_d < V_VIS);
    hs_d           = !((x_d >= H_SYNC_BEG) && (x_d < H_SYNC_END));
    vs_d           = !((y_d >= V_SYNC_BEG) && (y_d < V_SYNC_END));
    frame_start_d  = (x_d == 10'd0) && (y_d == 10'd0);
    vblank_start_d = (x_d == 10'd0) && (y_d == V_VIS);

    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Timing state; reset parks on the last pixel of a frame, which lies outside visible and sync regions.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q            <= H_LAST;
      y_q            <= V_LAST;
      blank_q        <= 1'b0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      blank_q        <= blank_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign DrawX        = x_q;
  assign DrawY        = y_q;
  assign blank        = blank_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign frame_count  = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;

  // Shift the coherent syncs along the delay line, newest sample entering stage 0.
  always_comb begin
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    hs_pipe_d[0] = hs_q;
    vs_pipe_d[0] = vs_q;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
    end
  end

  // Sync delay registers; reset to idle-high so no partial pulse survives a reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign hs = hs_pipe_q[PIPE_DELAY-1];
  assign vs = vs_pipe_q[PIPE_DELAY-1];
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a reduced-geometry instance (full-frame and
// 256-frame wrap coverage within a short run) plus a default 640x480 instance
// (reset state and line timing), both checked each cycle against a reference
// derived from the cycle count since the last reset edge. Random resets included.
module tb_vga_timing_controller;

  localparam int SH_V = 12;
  localparam int SH_F = 2;
  localparam int SH_S = 3;
  localparam int SH_B = 3;
  localparam int SV_V = 5;
  localparam int SV_F = 1;
  localparam int SV_S = 2;
  localparam int SV_B = 1;
  localparam int S_HT = SH_V + SH_F + SH_S + SH_B;
  localparam int S_VT = SV_V + SV_F + SV_S + SV_B;
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic       vga_clk;
  logic       reset;
  logic [9:0] s_x, s_y, d_x, d_y;
  logic       s_blank, s_hs, s_vs, s_fs, s_vb;
  logic       d_blank, d_hs, d_vs, d_fs, d_vb;
  logic [7:0] s_fc, d_fc;

  vga_timing_controller #(
    .H_VISIBLE(SH_V), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_VISIBLE(SV_V), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .PIPE_DELAY(2)
  ) dut_s (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .vblank_start(s_vb), .frame_count(s_fc)
  );

  vga_timing_controller dut_d (
    .vga_clk(vga_clk), .reset(reset), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs(d_hs), .vs(d_vs), .frame_start(d_fs), .vblank_start(d_vb), .frame_count(d_fc)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int n_total = 0;
  int n_bad   = 0;
  int k       = 0;   // edges since the last reset edge (0 = reset state showing)
  bit seen    = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_total++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp_v, k, $time);
    end
  endtask

  // Expected outputs after kk edges since reset, derived from raster arithmetic.
  task automatic model(input int kk, input int hv, input int hf, input int hsy, input int hb,
                       input int vv, input int vf, input int vsy, input int vb,
                       output int ex, output int ey, output int eb, output int ehs,
                       output int evs, output int efs, output int evb, output int efc);
    int ht, vt, p, q, qx, qy;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    if (kk == 0) begin
      ex = ht - 1; ey = vt - 1; eb = 0; ehs = 1; evs = 1; efs = 0; evb = 0; efc = 0;
    end else begin
      p   = kk - 1;
      ex  = p % ht;
      ey  = (p / ht) % vt;
      eb  = (ex < hv && ey < vv) ? 1 : 0;
      efs = (ex == 0 && ey == 0) ? 1 : 0;
      evb = (ex == 0 && ey == vv) ? 1 : 0;
      efc = (p / (ht * vt) + 1) % 256;
      ehs = 1;
      evs = 1;
      if (kk - DLY >= 1) begin
        q   = kk - DLY - 1;
        qx  = q % ht;
        qy  = (q / ht) % vt;
        ehs = (qx >= hv + hf && qx < hv + hf + hsy) ? 0 : 1;
        evs = (qy >= vv + vf && qy < vv + vf + vsy) ? 0 : 1;
      end
    end
  endtask

  // Reference position: count edges since the most recent reset edge.
  always @(posedge vga_clk) begin
    if (reset) begin
      k    <= 0;
      seen <= 1'b1;
    end else if (seen) begin
      k <= k + 1;
    end
  end

  int ex, ey, eb, ehs, evs, efs, evb, efc;
  int hs_run = 0;
  int vs_run = 0;
  int fs_last = 0;

  // Compare both instances against the reference every cycle, away from the active edge.
  always @(negedge vga_clk) begin
    if (seen) begin
      model(k, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, ex, ey, eb, ehs, evs, efs, evb, efc);
      chk("s_x", 32'(s_x), ex);
      chk("s_y", 32'(s_y), ey);
      chk("s_blank", 32'(s_blank), eb);
      chk("s_hs", 32'(s_hs), ehs);
      chk("s_vs", 32'(s_vs), evs);
      chk("s_fstart", 32'(s_fs), efs);
      chk("s_vbstart", 32'(s_vb), evb);
      chk("s_fcount", 32'(s_fc), efc);

      model(k, 640, 16, 96, 48, 480, 10, 2, 33, ex, ey, eb, ehs, evs, efs, evb, efc);
      chk("d_x", 32'(d_x), ex);
      chk("d_y", 32'(d_y), ey);
      chk("d_blank", 32'(d_blank), eb);
      chk("d_hs", 32'(d_hs), ehs);
      chk("d_vs", 32'(d_vs), evs);
      chk("d_fstart", 32'(d_fs), efs);
      chk("d_vbstart", 32'(d_vb), evb);
      chk("d_fcount", 32'(d_fc), efc);

      if (k == 0) begin
        hs_run  = 0;
        vs_run  = 0;
        fs_last = 0;
      end else begin
        if (!s_hs) begin
          hs_run++;
        end else begin
          if (hs_run > 0) chk("hs_width", hs_run, SH_S);
          hs_run = 0;
        end
        if (!s_vs) begin
          vs_run++;
        end else begin
          if (vs_run > 0) chk("vs_width", vs_run, SV_S * S_HT);
          vs_run = 0;
        end
        if (s_fs) begin
          if (fs_last > 0) chk("fs_period", k - fs_last, S_HT * S_VT);
          fs_last = k;
        end
      end
    end
  end

  int found;
  int n_cyc, m_cyc;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 reset = 1'b0;

    // Past 256 frame wraps on the reduced instance.
    repeat (257 * S_HT * S_VT + 50) @(posedge vga_clk);

    // One-cycle reset while the reduced instance is inside hsync.
    found = 0;
    for (int i = 0; i < 2 * S_HT * S_VT && found == 0; i++) begin
      @(negedge vga_clk);
      if (32'(s_x) == SH_V + SH_F + 1 && 32'(s_y) == 3) found = 1;
    end
    chk("find_hsync_pos", found, 1);
    reset = 1'b1;
    @(posedge vga_clk);
    #1 reset = 1'b0;
    @(negedge vga_clk);
    chk("midrst_hs", 32'(s_hs), 1);
    chk("midrst_x", 32'(s_x), S_HT - 1);
    @(negedge vga_clk);
    chk("midrst_fc", 32'(s_fc), 1);
    chk("midrst_fs", 32'(s_fs), 1);

    // Random run lengths and random reset pulses.
    for (int r = 0; r < 8; r++) begin
      n_cyc = $urandom_range(2000, 1);
      m_cyc = $urandom_range(3, 1);
      repeat (n_cyc) @(posedge vga_clk);
      #1 reset = 1'b1;
      repeat (m_cyc) @(posedge vga_clk);
      #1 reset = 1'b0;
    end

    repeat (500) @(posedge vga_clk);
    @(negedge vga_clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
